inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//  Instruction fetch stage of the light RV32I core; sits directly upstream of the instruction decoder/controller.
//  Owns the PC register and fetches one 32-bit word per instruction over a req/gnt/rvalid instruction-memory port.
//  Presents a stable instruction word plus PC to decode/execute, then advances the PC on a retire pulse.
//  Next PC is either sequential (PC+4) or a redirect target (taken branch/jump).
//  Flags misaligned redirect targets and counts retired instructions.
// PARAMETERS
//  XLEN        32            PC/address width
//  INST_WIDTH  32            instruction word width (matches `_INST_WIDTH_)
//  RESET_PC    32'h0000_0000 PC value loaded on reset
//  NOP_INST    32'h0000_0013 word driven on o_Instruction after reset (addi x0,x0,0)
// PORTS
//  i_Clk          in   1           core clock, rising edge
//  i_Rst          in   1           reset; one clock; asynchronous, active-high
//  o_IMemReq      out  1           fetch request, held until i_IMemGnt
//  o_IMemAddr     out  XLEN        fetch byte address (= o_Pc), valid while o_IMemReq
//  i_IMemGnt      in   1           memory accepts request this cycle
//  i_IMemRvalid   in   1           i_IMemRdata valid this cycle
//  i_IMemRdata    in   INST_WIDTH  fetched instruction word
//  o_Instruction  out  INST_WIDTH  current instruction to decoder (registered)
//  o_InstValid    out  1           o_Instruction/o_Pc describe a live instruction
//  o_Pc           out  XLEN        PC of o_Instruction
//  o_PcPlus4      out  XLEN        o_Pc + 4 (mod 2^XLEN)
//  i_Retire       in   1           single-cycle pulse: current instruction completed
//  i_Redirect     in   1           with i_Retire: next PC = i_TargetPc
//  i_TargetPc     in   XLEN        branch/jump target, sampled only with i_Retire & i_Redirect
//  o_Misaligned   out  1           sticky: redirect target with [1:0] != 0
//  o_RetireCnt    out  32          retired-instruction count
// BEHAVIOUR
//  Reset (async, i_Rst=1): state=S_IDLE, PC=RESET_PC, o_Instruction=NOP_INST, o_InstValid=0, o_IMemReq=0,
//   o_Misaligned=0, o_RetireCnt=0. Reset mid-fetch aborts the transaction; late rvalid after reset is ignored
//   until a new request is granted.
//  States and outputs:
//   S_IDLE : o_IMemReq=0; unconditionally -> S_FETCH next cycle.
//   S_FETCH: o_IMemReq=1, o_IMemAddr=PC. gnt&rvalid -> latch rdata, -> S_HOLD; gnt&!rvalid -> S_WAIT; else stay.
//   S_WAIT : o_IMemReq=0; rvalid -> latch rdata into o_Instruction, -> S_HOLD; else stay (no timeout).
//   S_HOLD : o_InstValid=1, o_Instruction/o_Pc stable. On i_Retire: RetireCnt+=1 (wraps),
//            nextPC = i_Redirect ? i_TargetPc : PC+4.
//            nextPC[1:0]!=0 -> o_Misaligned=1, PC unchanged, -> S_TRAP; else PC<=nextPC, -> S_FETCH.
//   S_TRAP : o_InstValid=0, o_IMemReq=0, o_Misaligned=1; held until reset.
//  o_InstValid is 0 in every state except S_HOLD; o_Instruction holds last value when not valid.
//  Latency: zero-wait memory (gnt&rvalid same cycle) -> o_InstValid 1 cycle after request; min throughput
//   one instruction per 2 cycles (HOLD, FETCH).
//  Ignored: i_Retire outside S_HOLD; i_Redirect/i_TargetPc without i_Retire; rvalid in S_IDLE/S_HOLD/S_TRAP
//   and rvalid in S_FETCH without gnt.
//  PC+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000. Only word-aligned addresses are ever issued.
// TESTING
//  1 Reset, zero-wait mem returning 32'h00500093 -> req at RESET_PC in cycle 2, o_InstValid cycle 3,
//    o_Instruction=32'h00500093, o_Pc=0, o_PcPlus4=4.
//  2 Memory with gnt after 2 cycles, rvalid 3 cycles later -> o_IMemReq held high until gnt,
//    o_InstValid only after rvalid, o_IMemAddr constant throughout.
//  3 Retire with i_Redirect=1, i_TargetPc=32'h0000_0100 -> next request address 32'h100; no redirect -> 32'h4.
//  4 Redirect to 32'h0000_0102 -> o_Misaligned=1, no further o_IMemReq, o_Pc unchanged, until reset.
//  5 Assert i_Rst while in S_WAIT, then late rvalid -> o_InstValid stays 0, o_Instruction=NOP_INST, fetch restarts at RESET_PC.
//  6 PC=32'hFFFF_FFFC retire without redirect -> next fetch at 0; o_RetireCnt from 32'hFFFF_FFFF wraps to 0.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per instruction over a
// req/gnt/rvalid port, holds it for decode and advances on a retire pulse.
module inst_fetch_unit #(
  parameter int unsigned            XLEN             = 32,
  parameter int unsigned            INST_WIDTH       = 32,
  parameter logic [XLEN-1:0]        RESET_PC         = 32'h0000_0000,
  parameter logic [INST_WIDTH-1:0]  NOP_INST         = 32'h0000_0013,
  parameter logic [31:0]            RETIRE_CNT_INIT  = 32'h0000_0000
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  output logic                  o_IMemReq,
  output logic [XLEN-1:0]       o_IMemAddr,
  input  logic                  i_IMemGnt,
  input  logic                  i_IMemRvalid,
  input  logic [INST_WIDTH-1:0] i_IMemRdata,
  output logic [INST_WIDTH-1:0] o_Instruction,
  output logic                  o_InstValid,
  output logic [XLEN-1:0]       o_Pc,
  output logic [XLEN-1:0]       o_PcPlus4,
  input  logic                  i_Retire,
  input  logic                  i_Redirect,
  input  logic [XLEN-1:0]       i_TargetPc,
  output logic                  o_Misaligned,
  output logic [31:0]           o_RetireCnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_TRAP  = 3'd4
  } state_t;

  state_t                  r_state;
  logic [XLEN-1:0]         r_pc;
  logic [INST_WIDTH-1:0]   r_inst;
  logic                    r_req;
  logic                    r_valid;
  logic                    r_misaligned;
  logic [31:0]             r_retire_cnt;

  logic [XLEN-1:0]         w_pc_plus4;
  logic [XLEN-1:0]         w_next_pc;
  logic                    w_next_misaligned;

  assign w_pc_plus4        = r_pc + XLEN'(4);
  assign w_next_pc         = i_Redirect ? i_TargetPc : w_pc_plus4;
  assign w_next_misaligned = (w_next_pc[1:0] != 2'b00);

  // Outputs come straight from registers updated alongside the state.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_inst       <= NOP_INST;
      r_req        <= 1'b0;
      r_valid      <= 1'b0;
      r_misaligned <= 1'b0;
      r_retire_cnt <= RETIRE_CNT_INIT;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
          r_req   <= 1'b1;
        end
        S_FETCH: begin
          if (i_IMemGnt && i_IMemRvalid) begin
            r_inst  <= i_IMemRdata;
            r_req   <= 1'b0;
            r_valid <= 1'b1;
            r_state <= S_HOLD;
          end else if (i_IMemGnt) begin
            r_req   <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_IMemRvalid) begin
            r_inst  <= i_IMemRdata;
            r_valid <= 1'b1;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (i_Retire) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
            r_valid      <= 1'b0;
            // A misaligned target is never issued; the PC stays on the faulting instruction.
            if (w_next_misaligned) begin
              r_misaligned <= 1'b1;
              r_state      <= S_TRAP;
            end else begin
              r_pc    <= w_next_pc;
              r_req   <= 1'b1;
              r_state <= S_FETCH;
            end
          end
        end
        S_TRAP: begin
          r_req        <= 1'b0;
          r_valid      <= 1'b0;
          r_misaligned <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_IMemReq     = r_req;
  assign o_IMemAddr    = r_pc;
  assign o_Instruction = r_inst;
  assign o_InstValid   = r_valid;
  assign o_Pc          = r_pc;
  assign o_PcPlus4     = w_pc_plus4;
  assign o_Misaligned  = r_misaligned;
  assign o_RetireCnt   = r_retire_cnt;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit; a second instance starts near the PC and
// retire-count limits to exercise wrap-around without billions of cycles.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, gnt, rvalid, valid, misal;
  logic [31:0] addr, rdata, inst, pc, pcp4, rcnt;
  logic        retire, redirect;
  logic [31:0] target;

  logic        mem_manual;
  logic        man_gnt, man_rvalid;
  logic [31:0] man_rdata;

  logic        req_w, valid_w, misal_w, retire_w;
  logic [31:0] addr_w, inst_w, pc_w, pcp4_w, rcnt_w;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'h0000_0013);
  endfunction

  // Zero-wait memory unless the bench takes manual control of the handshake.
  always_comb begin
    gnt    = req;
    rvalid = req;
    rdata  = mem_word(addr);
    if (mem_manual) begin
      gnt    = man_gnt;
      rvalid = man_rvalid;
      rdata  = man_rdata;
    end
  end

  inst_fetch_unit dut (
    .i_Clk(clk), .i_Rst(rst),
    .o_IMemReq(req), .o_IMemAddr(addr),
    .i_IMemGnt(gnt), .i_IMemRvalid(rvalid), .i_IMemRdata(rdata),
    .o_Instruction(inst), .o_InstValid(valid), .o_Pc(pc), .o_PcPlus4(pcp4),
    .i_Retire(retire), .i_Redirect(redirect), .i_TargetPc(target),
    .o_Misaligned(misal), .o_RetireCnt(rcnt)
  );

  inst_fetch_unit #(
    .RESET_PC(32'hFFFF_FFFC),
    .RETIRE_CNT_INIT(32'hFFFF_FFFF)
  ) dut_w (
    .i_Clk(clk), .i_Rst(rst),
    .o_IMemReq(req_w), .o_IMemAddr(addr_w),
    .i_IMemGnt(req_w), .i_IMemRvalid(req_w), .i_IMemRdata(32'h0000_0013),
    .o_Instruction(inst_w), .o_InstValid(valid_w), .o_Pc(pc_w), .o_PcPlus4(pcp4_w),
    .i_Retire(retire_w), .i_Redirect(1'b0), .i_TargetPc(32'h0),
    .o_Misaligned(misal_w), .o_RetireCnt(rcnt_w)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic retire_pulse(input logic redir, input logic [31:0] tgt);
    retire = 1'b1; redirect = redir; target = tgt;
    tick();
    retire = 1'b0; redirect = 1'b0; target = 32'h0;
  endtask

  initial begin
    int req_seen;
    rst = 1'b1; retire = 1'b0; redirect = 1'b0; target = 32'h0; retire_w = 1'b0;
    mem_manual = 1'b0; man_gnt = 1'b0; man_rvalid = 1'b0; man_rdata = 32'h0;
    tick(); tick();
    rst = 1'b0;

    // Reset state, then zero-wait fetch at RESET_PC
    check_val("rst_req",   {31'd0, req},   32'd0);
    check_val("rst_valid", {31'd0, valid}, 32'd0);
    check_val("rst_inst",  inst,           32'h0000_0013);
    check_val("rst_pc",    pc,             32'h0);
    check_val("rst_misal", {31'd0, misal}, 32'd0);
    check_val("rst_cnt",   rcnt,           32'h0);
    tick();
    check_val("t1_req",    {31'd0, req},   32'd1);
    check_val("t1_addr",   addr,           32'h0);
    check_val("t1_valid0", {31'd0, valid}, 32'd0);
    tick();
    check_val("t1_valid",  {31'd0, valid}, 32'd1);
    check_val("t1_inst",   inst,           32'h0050_0093);
    check_val("t1_pc",     pc,             32'h0);
    check_val("t1_pcp4",   pcp4,           32'h4);

    // Sequential retire then redirect
    retire_pulse(1'b0, 32'h0);
    check_val("t3_seq_addr", addr,           32'h4);
    check_val("t3_seq_req",  {31'd0, req},   32'd1);
    check_val("t3_cnt1",     rcnt,           32'd1);
    tick();
    check_val("t3_seq_inst", inst,           32'h0000_0017);
    retire_pulse(1'b1, 32'h0000_0100);
    check_val("t3_red_addr", addr,           32'h100);
    tick();
    check_val("t3_red_valid", {31'd0, valid}, 32'd1);
    check_val("t3_red_inst", inst,           32'h0000_0113);
    check_val("t3_red_pcp4", pcp4,           32'h104);
    check_val("t3_cnt2",     rcnt,           32'd2);

    // Slow memory: grant after 2 cycles, data 3 cycles after grant
    mem_manual = 1'b1;
    retire_pulse(1'b0, 32'h0);
    check_val("t2_req_c0",  {31'd0, req}, 32'd1);
    check_val("t2_addr_c0", addr,         32'h104);
    tick();
    check_val("t2_req_c1",  {31'd0, req}, 32'd1);
    check_val("t2_addr_c1", addr,         32'h104);
    man_gnt = 1'b1;
    tick();
    man_gnt = 1'b0;
    check_val("t2_req_drop", {31'd0, req},   32'd0);
    check_val("t2_wait_v0",  {31'd0, valid}, 32'd0);
    tick();
    check_val("t2_wait_v1",  {31'd0, valid}, 32'd0);
    check_val("t2_addr_w",   addr,           32'h104);
    man_rvalid = 1'b1; man_rdata = 32'hDEAD_BEEF;
    tick();
    man_rvalid = 1'b0;
    check_val("t2_valid", {31'd0, valid}, 32'd1);
    check_val("t2_inst",  inst,           32'hDEAD_BEEF);
    check_val("t2_pc",    pc,             32'h104);
    check_val("t2_hold_req", {31'd0, req}, 32'd0);

    // Reset while waiting for data; late rvalid must be ignored
    retire_pulse(1'b0, 32'h0);
    man_gnt = 1'b1;
    tick();
    man_gnt = 1'b0;
    check_val("t5_in_wait", {31'd0, req}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check_val("t5_rst_valid", {31'd0, valid}, 32'd0);
    check_val("t5_rst_inst",  inst,           32'h0000_0013);
    tick();
    rst = 1'b0;
    man_rvalid = 1'b1; man_rdata = 32'hBAD0_BAD0;
    tick();
    check_val("t5_late_valid", {31'd0, valid}, 32'd0);
    check_val("t5_late_inst",  inst,           32'h0000_0013);
    check_val("t5_refetch",    addr,           32'h0);
    check_val("t5_refetch_req", {31'd0, req},  32'd1);
    tick();
    check_val("t5_nogt_valid", {31'd0, valid}, 32'd0);
    man_rvalid = 1'b0;
    mem_manual = 1'b0;
    tick();
    check_val("t5_valid", {31'd0, valid}, 32'd1);
    check_val("t5_inst",  inst,           32'h0050_0093);
    check_val("t5_cnt",   rcnt,           32'h0);

    // Misaligned redirect traps until reset
    retire_pulse(1'b1, 32'h0000_0102);
    check_val("t4_misal", {31'd0, misal}, 32'd1);
    check_val("t4_valid", {31'd0, valid}, 32'd0);
    check_val("t4_pc",    pc,             32'h0);
    check_val("t4_cnt",   rcnt,           32'd1);
    req_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (req) req_seen++;
      retire = (i == 2);
      tick();
    end
    retire = 1'b0;
    check_val("t4_no_req",   req_seen,       32'd0);
    check_val("t4_sticky",   {31'd0, misal}, 32'd1);
    check_val("t4_pc_held",  pc,             32'h0);

    // PC and retire-count wrap on the second instance
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick();
    check_val("t4_cleared",  {31'd0, misal}, 32'd0);
    check_val("t6_valid",    {31'd0, valid_w}, 32'd1);
    check_val("t6_pc",       pc_w,   32'hFFFF_FFFC);
    check_val("t6_pcp4",     pcp4_w, 32'h0);
    check_val("t6_cnt_pre",  rcnt_w, 32'hFFFF_FFFF);
    retire_w = 1'b1;
    tick();
    retire_w = 1'b0;
    check_val("t6_addr",     addr_w, 32'h0);
    check_val("t6_req",      {31'd0, req_w},   32'd1);
    check_val("t6_cnt_wrap", rcnt_w, 32'h0);
    check_val("t6_no_misal", {31'd0, misal_w}, 32'd0);
    tick();
    check_val("t6_pc_new",   pc_w,   32'h0);
    check_val("t6_inst",     inst_w, 32'h0000_0013);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
